dcache_req_port_arbiter: RTL and testbench

//  Shares the single write-through dcache request port between NR_PORTS requesters
//  (0=PTW, 1=load unit, 2=store unit). Uses round-robin arbitration and caps in-flight

---
 rtl/dcache_req_port_arbiter.sv | 136 +++++++++++++
 tb/tb_dcache_req_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_req_port_arbiter.sv
// Round-robin arbiter sharing one in-order dcache request port between requesters.
// Tracks in-flight requests in a port-index FIFO so responses return to their issuer.
module dcache_req_port_arbiter #(
    parameter int unsigned NR_PORTS        = 3,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 7
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NR_PORTS-1:0]                    req_valid_i,
    output logic [NR_PORTS-1:0]                    req_ready_o,
    input  logic [NR_PORTS*ADDR_W-1:0]             req_addr_i,
    input  logic [NR_PORTS-1:0]                    req_we_i,
    input  logic [NR_PORTS*DATA_W-1:0]             req_wdata_i,
    input  logic [NR_PORTS*DATA_W/8-1:0]           req_be_i,
    output logic                                   mem_req_valid_o,
    input  logic                                   mem_req_ready_i,
    output logic [ADDR_W-1:0]                      mem_req_addr_o,
    output logic                                   mem_req_we_o,
    output logic [DATA_W-1:0]                      mem_req_wdata_o,
    output logic [DATA_W/8-1:0]                    mem_req_be_o,
    input  logic                                   mem_rsp_valid_i,
    input  logic [DATA_W-1:0]                      mem_rsp_rdata_i,
    output logic [NR_PORTS-1:0]                    rsp_valid_o,
    output logic [DATA_W-1:0]                      rsp_rdata_o,
    input  logic                                   drain_req_i,
    output logic                                   drain_done_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   rsp_err_o
);

    localparam int unsigned PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned BW = DATA_W / 8;

    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_OUTSTANDING);
    localparam logic [AW-1:0] PTR_LAST  = AW'(MAX_OUTSTANDING - 1);
    localparam logic [PW-1:0] PORT_LAST = PW'(NR_PORTS - 1);

    typedef enum logic [1:0] {
        ARB,
        HOLD,
        DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] rr_q, held_q, arb_idx, grant;
    logic          arb_found, issue, accept, pop;
    logic [CW-1:0] count_q;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [PW-1:0] fifo_q [MAX_OUTSTANDING];
    logic          err_q;

    always_comb begin
        int j;
        j         = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < int'(NR_PORTS); i++) begin
            j = int'(rr_q) + i;
            if (j >= int'(NR_PORTS)) j = j - int'(NR_PORTS);
            if (!arb_found && req_valid_i[PW'(j)]) begin
                arb_found = 1'b1;
                arb_idx   = PW'(j);
            end
        end
    end

    // A held grant must be reissued regardless of drain or count.
    assign issue = (state_q == HOLD) ||
                   ((state_q == ARB) && !drain_req_i &&
                    (count_q < CNT_MAX) && arb_found);
    assign grant  = (state_q == HOLD) ? held_q : arb_idx;
    assign accept = issue && mem_req_ready_i;
    assign pop    = mem_rsp_valid_i && (count_q != '0);

    assign mem_req_valid_o = issue;
    assign mem_req_addr_o  = issue ? req_addr_i[grant*ADDR_W +: ADDR_W] : '0;
    assign mem_req_we_o    = issue && req_we_i[grant];
    assign mem_req_wdata_o = issue ? req_wdata_i[grant*DATA_W +: DATA_W] : '0;
    assign mem_req_be_o    = issue ? req_be_i[grant*BW +: BW] : '0;

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
        assign req_ready_o[p] = accept && (grant == PW'(p));
        assign rsp_valid_o[p] = pop && (fifo_q[rptr_q] == PW'(p));
    end

    assign rsp_rdata_o   = pop ? mem_rsp_rdata_i : '0;
    assign drain_done_o  = (state_q == DRAIN) && (count_q == '0);
    assign outstanding_o = count_q;
    assign rsp_err_o     = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB: begin
                if (drain_req_i)           state_d = DRAIN;
                else if (issue && !accept) state_d = HOLD;
            end
            HOLD: begin
                if (accept) state_d = ARB;
            end
            DRAIN: begin
                if (!drain_req_i) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
            rr_q    <= '0;
            held_q  <= '0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ARB) && issue) held_q <= arb_idx;
            if (accept) begin
                fifo_q[wptr_q] <= grant;
                rr_q   <= (grant == PORT_LAST) ? '0 : grant + PW'(1);
                wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + AW'(1);
            end
            if (pop) rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + AW'(1);
            count_q <= count_q + CW'(accept) - CW'(pop);
            if (mem_rsp_valid_i && (count_q == '0)) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_req_port_arbiter.sv
// Directed bench for dcache_req_port_arbiter: arbitration, hold, throttle,
// response routing, drain and orphan-response error.
module tb_dcache_req_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 7;
    localparam int CW = $clog2(MO + 1);

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [NP-1:0]     req_valid_i;
    logic [NP-1:0]     req_ready_o;
    logic [NP*AW-1:0]  req_addr_i;
    logic [NP-1:0]     req_we_i;
    logic [NP*DW-1:0]  req_wdata_i;
    logic [NP*DW/8-1:0] req_be_i;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [AW-1:0]     mem_req_addr_o;
    logic              mem_req_we_o;
    logic [DW-1:0]     mem_req_wdata_o;
    logic [DW/8-1:0]   mem_req_be_o;
    logic              mem_rsp_valid_i;
    logic [DW-1:0]     mem_rsp_rdata_i;
    logic [NP-1:0]     rsp_valid_o;
    logic [DW-1:0]     rsp_rdata_o;
    logic              drain_req_i;
    logic              drain_done_o;
    logic [CW-1:0]     outstanding_o;
    logic              rsp_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dcache_req_port_arbiter #(
        .NR_PORTS       (NP),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_we_i       (req_we_i),
        .req_wdata_i    (req_wdata_i),
        .req_be_i       (req_be_i),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o (mem_req_addr_o),
        .mem_req_we_o   (mem_req_we_o),
        .mem_req_wdata_o(mem_req_wdata_o),
        .mem_req_be_o   (mem_req_be_o),
        .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_rdata_i(mem_rsp_rdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .drain_req_i    (drain_req_i),
        .drain_done_o   (drain_done_o),
        .outstanding_o  (outstanding_o),
        .rsp_err_o      (rsp_err_o)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NP-1:0] oh(input int p);
        logic [NP-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int p);
        return 32'h0000_1000 + 32'(p) * 32'h10;
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int p);
        return 32'hD000_0000 + 32'(p);
    endfunction

    initial begin
        rst_ni          = 1'b0;
        req_valid_i     = '0;
        req_we_i        = 3'b100;
        req_be_i        = {4'hC, 4'hA, 4'h5};
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_rdata_i = '0;
        drain_req_i     = 1'b0;
        for (int p = 0; p < NP; p++) begin
            req_addr_i[p*AW +: AW]  = addr_of(p);
            req_wdata_i[p*DW +: DW] = wdata_of(p);
        end

        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_valid", 64'(mem_req_valid_o), 0);
        check("rst_ready", 64'(req_ready_o), 0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 0);
        check("rst_outstanding", 64'(outstanding_o), 0);
        check("rst_drain_done", 64'(drain_done_o), 0);
        check("rst_err", 64'(rsp_err_o), 0);

        @(negedge clk);
        rst_ni = 1'b1;

        // round robin with all ports valid
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req_valid_i     = 3'b111;
            mem_req_ready_i = 1'b1;
            #1;
            check("rr_ready", 64'(req_ready_o), 64'(oh(k % 3)));
            check("rr_addr", 64'(mem_req_addr_o), 64'(addr_of(k % 3)));
            check("rr_wdata", 64'(mem_req_wdata_o), 64'(wdata_of(k % 3)));
            check("rr_we", 64'(mem_req_we_o), 64'((k % 3) == 2));
        end
        @(negedge clk);
        req_valid_i = '0;
        #1;
        check("rr_outstanding", 64'(outstanding_o), 6);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            mem_rsp_valid_i = 1'b1;
            mem_rsp_rdata_i = 32'h100 + 32'(k);
            #1;
            check("rr_rsp_valid", 64'(rsp_valid_o), 64'(oh(k % 3)));
            check("rr_rsp_data", 64'(rsp_rdata_o), 64'(32'h100 + 32'(k)));
        end
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        #1;
        check("rr_drained", 64'(outstanding_o), 0);

        // hold: port 1 stalled three cycles, port 2 raised meanwhile
        @(negedge clk);
        req_valid_i     = 3'b010;
        mem_req_ready_i = 1'b0;
        #1;
        check("hold_valid", 64'(mem_req_valid_o), 1);
        check("hold_ready0", 64'(req_ready_o), 0);
        @(negedge clk);
        req_valid_i = 3'b110;
        #1;
        check("hold_addr1", 64'(mem_req_addr_o), 64'(addr_of(1)));
        @(negedge clk);
        #1;
        check("hold_addr2", 64'(mem_req_addr_o), 64'(addr_of(1)));
        check("hold_ready2", 64'(req_ready_o), 0);
        @(negedge clk);
        mem_req_ready_i = 1'b1;
        #1;
        check("hold_accept", 64'(req_ready_o), 64'(oh(1)));
        @(negedge clk);
        #1;
        check("hold_next", 64'(req_ready_o), 64'(oh(2)));
        @(negedge clk);
        req_valid_i = '0;
        #1;
        check("hold_outstanding", 64'(outstanding_o), 2);

        // drain with two in flight
        @(negedge clk);
        drain_req_i = 1'b1;
        req_valid_i = 3'b111;
        #1;
        check("drain_no_issue0", 64'(mem_req_valid_o), 0);
        check("drain_done0", 64'(drain_done_o), 0);
        @(negedge clk);
        #1;
        check("drain_no_issue1", 64'(mem_req_valid_o), 0);
        check("drain_done1", 64'(drain_done_o), 0);
        @(negedge clk);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_rdata_i = 32'h11;
        #1;
        check("drain_rsp1", 64'(rsp_valid_o), 64'(oh(1)));
        check("drain_done2", 64'(drain_done_o), 0);
        @(negedge clk);
        mem_rsp_rdata_i = 32'h22;
        #1;
        check("drain_rsp2", 64'(rsp_valid_o), 64'(oh(2)));
        check("drain_done3", 64'(drain_done_o), 0);
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        #1;
        check("drain_done", 64'(drain_done_o), 1);
        check("drain_no_issue2", 64'(mem_req_valid_o), 0);
        @(negedge clk);
        drain_req_i = 1'b0;
        req_valid_i = '0;
        @(negedge clk);
        #1;
        check("drain_exit", 64'(drain_done_o), 0);

        // throttle at MAX_OUTSTANDING
        for (int k = 0; k < MO; k++) begin
            @(negedge clk);
            req_valid_i     = 3'b001;
            mem_req_ready_i = 1'b1;
            #1;
            check("full_fill", 64'(req_ready_o), 64'(oh(0)));
        end
        @(negedge clk);
        #1;
        check("full_blocked", 64'(mem_req_valid_o), 0);
        check("full_count", 64'(outstanding_o), 7);
        @(negedge clk);
        mem_rsp_valid_i = 1'b1;
        #1;
        check("full_rsp_blocked", 64'(mem_req_valid_o), 0);
        check("full_rsp", 64'(rsp_valid_o), 64'(oh(0)));
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        #1;
        check("full_resume", 64'(mem_req_valid_o), 1);
        check("full_count6", 64'(outstanding_o), 6);
        for (int k = 0; k < MO; k++) begin
            @(negedge clk);
            req_valid_i     = '0;
            mem_rsp_valid_i = 1'b1;
            #1;
            check("full_unload", 64'(rsp_valid_o), 64'(oh(0)));
        end
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        #1;
        check("full_empty", 64'(outstanding_o), 0);

        // response routing order 2,0,1
        @(negedge clk);
        req_valid_i = 3'b100;
        #1;
        check("ord_req2", 64'(req_ready_o), 64'(oh(2)));
        @(negedge clk);
        req_valid_i = 3'b001;
        #1;
        check("ord_req0", 64'(req_ready_o), 64'(oh(0)));
        @(negedge clk);
        req_valid_i = 3'b010;
        #1;
        check("ord_req1", 64'(req_ready_o), 64'(oh(1)));
        @(negedge clk);
        req_valid_i     = '0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_rdata_i = 32'hA;
        #1;
        check("ord_rsp_a", 64'(rsp_valid_o), 64'(3'b100));
        check("ord_data_a", 64'(rsp_rdata_o), 64'hA);
        @(negedge clk);
        mem_rsp_rdata_i = 32'hB;
        #1;
        check("ord_rsp_b", 64'(rsp_valid_o), 64'(3'b001));
        check("ord_data_b", 64'(rsp_rdata_o), 64'hB);
        @(negedge clk);
        mem_rsp_rdata_i = 32'hC;
        #1;
        check("ord_rsp_c", 64'(rsp_valid_o), 64'(3'b010));
        check("ord_data_c", 64'(rsp_rdata_o), 64'hC);
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        #1;
        check("ord_empty", 64'(outstanding_o), 0);
        check("ord_no_err", 64'(rsp_err_o), 0);

        // orphan response sets sticky error
        @(negedge clk);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_rdata_i = 32'hEE;
        #1;
        check("err_no_rsp", 64'(rsp_valid_o), 0);
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        #1;
        check("err_set", 64'(rsp_err_o), 1);
        check("err_count", 64'(outstanding_o), 0);
        @(negedge clk);
        req_valid_i = 3'b001;
        #1;
        check("err_sticky_req", 64'(req_ready_o), 64'(oh(0)));
        @(negedge clk);
        req_valid_i = '0;
        #1;
        check("err_sticky", 64'(rsp_err_o), 1);
        check("err_inflight", 64'(outstanding_o), 1);
        rst_ni = 1'b0;
        #1;
        check("async_rst_err", 64'(rsp_err_o), 0);
        check("async_rst_count", 64'(outstanding_o), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        mem_rsp_valid_i = 1'b1;
        #1;
        check("late_no_rsp", 64'(rsp_valid_o), 0);
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        #1;
        check("late_err", 64'(rsp_err_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
